// File: rtl/vc_buffer.sv
// vc_buffer: multi-virtual-channel input buffer for one router port.
// NUM_VC independent circular FIFOs share one write port and one read port.
// Each VC provides full/empty/almost_full/usedw status, a credit pulse for
// every accepted pop, and sticky overflow/underflow error flags.
// A per-VC occupancy counter lets every one of the DEPTH slots hold a flit.
module vc_buffer #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 8,
    parameter int NUM_VC    = 2,
    parameter int AF_THRESH = DEPTH - 2,
    localparam int VC_W     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [VC_W-1:0]         in_vc,
    input  logic                    produce,
    input  logic [VC_W-1:0]         rd_vc,
    input  logic                    consume,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [NUM_VC-1:0]       full,
    output logic [NUM_VC-1:0]       empty,
    output logic [NUM_VC-1:0]       almost_full,
    output logic [NUM_VC*CNT_W-1:0] usedw,
    output logic                    credit_valid,
    output logic [VC_W-1:0]         credit_vc,
    output logic                    err_overflow,
    output logic                    err_underflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Flit storage; it is deliberately left out of reset.
    logic [WIDTH-1:0] mem [NUM_VC][DEPTH];

    logic [PTR_W-1:0] head_q  [NUM_VC];
    logic [PTR_W-1:0] head_d  [NUM_VC];
    logic [PTR_W-1:0] tail_q  [NUM_VC];
    logic [PTR_W-1:0] tail_d  [NUM_VC];
    logic [CNT_W-1:0] count_q [NUM_VC];
    logic [CNT_W-1:0] count_d [NUM_VC];

    logic             credit_valid_q, credit_valid_d;
    logic [VC_W-1:0]  credit_vc_q, credit_vc_d;
    logic             err_overflow_q, err_overflow_d;
    logic             err_underflow_q, err_underflow_d;

    logic [NUM_VC-1:0] wr_hit;
    logic [NUM_VC-1:0] rd_hit;
    logic              wr_ok;
    logic              rd_ok;

    // Pointers wrap from DEPTH-1 back to 0, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Per-VC accept decisions, judged on the pre-edge count. An out-of-range
    // VC index matches no channel, so it is rejected automatically.
    always_comb begin
        wr_hit = '0;
        rd_hit = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            wr_hit[v] = produce && (in_vc == VC_W'(v)) && (count_q[v] != CNT_W'(DEPTH));
            rd_hit[v] = consume && (rd_vc == VC_W'(v)) && (count_q[v] != '0);
        end
        wr_ok = |wr_hit;
        rd_ok = |rd_hit;
    end

    // Next-state values for the pointers, counters, credit return and sticky errors.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            head_d[v]  = rd_hit[v] ? next_ptr(head_q[v]) : head_q[v];
            tail_d[v]  = wr_hit[v] ? next_ptr(tail_q[v]) : tail_q[v];
            count_d[v] = count_q[v];
            if (wr_hit[v] && !rd_hit[v]) begin
                count_d[v] = count_q[v] + CNT_W'(1);
            end else if (!wr_hit[v] && rd_hit[v]) begin
                count_d[v] = count_q[v] - CNT_W'(1);
            end
        end
        credit_valid_d  = rd_ok;
        credit_vc_d     = rd_ok ? rd_vc : credit_vc_q;
        err_overflow_d  = err_overflow_q | (produce & ~wr_ok);
        err_underflow_d = err_underflow_q | (consume & ~rd_ok);
    end

    // State registers; an asynchronous reset discards every VC's contents at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                head_q[v]  <= '0;
                tail_q[v]  <= '0;
                count_q[v] <= '0;
            end
            credit_valid_q  <= 1'b0;
            credit_vc_q     <= '0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                head_q[v]  <= head_d[v];
                tail_q[v]  <= tail_d[v];
                count_q[v] <= count_d[v];
            end
            credit_valid_q  <= credit_valid_d;
            credit_vc_q     <= credit_vc_d;
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    // Flit storage write at the tail of the accepted VC.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (wr_hit[v]) begin
                mem[v][tail_q[v]] <= in_data;
            end
        end
    end

    // Status flags and the show-ahead head flit of rd_vc, all from registered state.
    always_comb begin
        full        = '0;
        empty       = '0;
        almost_full = '0;
        usedw       = '0;
        out_valid   = 1'b0;
        out_data    = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            full[v]                 = (count_q[v] == CNT_W'(DEPTH));
            empty[v]                = (count_q[v] == '0);
            almost_full[v]          = (count_q[v] >= CNT_W'(AF_THRESH));
            usedw[v*CNT_W +: CNT_W] = count_q[v];
            if ((rd_vc == VC_W'(v)) && (count_q[v] != '0)) begin
                out_valid = 1'b1;
                out_data  = mem[v][head_q[v]];
            end
        end
    end

    assign credit_valid  = credit_valid_q;
    assign credit_vc     = credit_vc_q;
    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_vc_buffer.sv
// tb_vc_buffer: randomized, self-checking bench for vc_buffer with two VCs.
// A queue-per-VC reference model predicts occupancy, head flit, credits and errors.
module tb_vc_buffer;

    localparam int WIDTH  = 64;
    localparam int DEPTH  = 8;
    localparam int NUM_VC = 2;
    localparam int AF     = DEPTH - 2;
    localparam int CNT_W  = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_vc;
    logic             produce;
    logic             rd_vc;
    logic             consume;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [1:0]       full;
    logic [1:0]       empty;
    logic [1:0]       almost_full;
    logic [7:0]       usedw;
    logic             credit_valid;
    logic             credit_vc;
    logic             err_overflow;
    logic             err_underflow;

    int checks;
    int passes;

    // Reference model: one FIFO queue per VC plus credit/error expectations.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    bit               m_cv;
    logic             m_cvc;
    bit               m_ovf;
    bit               m_unf;

    vc_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_VC(NUM_VC), .AF_THRESH(AF)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_vc(in_vc), .produce(produce),
        .rd_vc(rd_vc), .consume(consume), .out_data(out_data), .out_valid(out_valid),
        .full(full), .empty(empty), .almost_full(almost_full), .usedw(usedw),
        .credit_valid(credit_valid), .credit_vc(credit_vc),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int msize(input logic v);
        return (v == 1'b0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [WIDTH-1:0] mhead(input logic v);
        if (msize(v) == 0) return '0;
        return (v == 1'b0) ? q0[0] : q1[0];
    endfunction

    function automatic logic [7:0] exp_usedw();
        return {CNT_W'(q1.size()), CNT_W'(q0.size())};
    endfunction

    function automatic logic [1:0] exp_full();
        return {q1.size() == DEPTH, q0.size() == DEPTH};
    endfunction

    function automatic logic [1:0] exp_empty();
        return {q1.size() == 0, q0.size() == 0};
    endfunction

    function automatic logic [1:0] exp_af();
        return {q1.size() >= AF, q0.size() >= AF};
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_cv  = 0;
        m_cvc = 1'b0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    // Drive one cycle of inputs, advance the model from the pre-edge occupancy,
    // and return #1 after the edge so outputs can be sampled.
    task automatic do_cycle(input bit p, input logic ivc, input logic [WIDTH-1:0] d,
                            input bit c, input logic rvc);
        bit wr;
        bit rd;
        produce = p;
        in_vc   = ivc;
        in_data = d;
        consume = c;
        rd_vc   = rvc;
        @(posedge clk);
        wr = p && (msize(ivc) < DEPTH);
        rd = c && (msize(rvc) > 0);
        if (rd) begin
            if (rvc == 1'b0) void'(q0.pop_front());
            else             void'(q1.pop_front());
        end
        if (wr) begin
            if (ivc == 1'b0) q0.push_back(d);
            else             q1.push_back(d);
        end
        m_cv = rd;
        if (rd) m_cvc = rvc;
        if (p && !wr) m_ovf = 1;
        if (c && !rd) m_unf = 1;
        #1;
        produce = 1'b0;
        consume = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        produce = 1'b0; consume = 1'b0; in_vc = 1'b0; rd_vc = 1'b0; in_data = '0;
        model_reset();
        #3;
        checks++; if (empty !== 2'b11) $display("[TB] FAIL reset_empty: got %b expected 11", empty); else passes++;
        checks++; if (full !== 2'b00) $display("[TB] FAIL reset_full: got %b expected 00", full); else passes++;
        checks++; if (usedw !== 8'h00) $display("[TB] FAIL reset_usedw: got %h expected 00", usedw); else passes++;
        checks++; if (out_valid !== 1'b0 || out_data !== '0) $display("[TB] FAIL reset_out: got valid=%b data=%h expected 0/0", out_valid, out_data); else passes++;
        checks++; if ({credit_valid, err_overflow, err_underflow, almost_full} !== 5'b0) $display("[TB] FAIL reset_flags: got %b expected 00000", {credit_valid, err_overflow, err_underflow, almost_full}); else passes++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1, 1'b0, WIDTH'(8'h10 + i), 0, 1'b0);
            checks++; if (usedw !== exp_usedw()) $display("[TB] FAIL fill_usedw: got %h expected %h", usedw, exp_usedw()); else passes++;
            checks++; if (almost_full[0] !== (i + 1 >= AF)) $display("[TB] FAIL fill_af: got %b expected %b", almost_full[0], (i + 1 >= AF)); else passes++;
            checks++; if (full !== exp_full() || empty !== exp_empty()) $display("[TB] FAIL fill_flags: got full=%b empty=%b expected %b/%b", full, empty, exp_full(), exp_empty()); else passes++;
        end
        checks++; if (usedw[3:0] !== 4'd8 || full[0] !== 1'b1) $display("[TB] FAIL fill_full: got usedw0=%0d full0=%b expected 8/1", usedw[3:0], full[0]); else passes++;
        checks++; if (err_overflow !== 1'b0) $display("[TB] FAIL ovf_early: got %b expected 0", err_overflow); else passes++;
        do_cycle(1, 1'b0, 64'h99, 0, 1'b0);
        checks++; if (err_overflow !== 1'b1 || usedw[3:0] !== 4'd8) $display("[TB] FAIL overflow: got ovf=%b usedw0=%0d expected 1/8", err_overflow, usedw[3:0]); else passes++;
    endtask

    task automatic test_drain();
        rd_vc = 1'b0;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== WIDTH'(8'h10 + i)) $display("[TB] FAIL drain_data: got valid=%b data=%h expected 1/%h", out_valid, out_data, 8'h10 + i); else passes++;
            do_cycle(0, 1'b0, '0, 1, 1'b0);
            checks++; if (credit_valid !== 1'b1 || credit_vc !== 1'b0) $display("[TB] FAIL drain_credit: got %b/%b expected 1/0", credit_valid, credit_vc); else passes++;
        end
        checks++; if (empty[0] !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) $display("[TB] FAIL drain_empty: got empty0=%b valid=%b data=%h expected 1/0/0", empty[0], out_valid, out_data); else passes++;
        do_cycle(0, 1'b0, '0, 0, 1'b0);
        checks++; if (credit_valid !== 1'b0) $display("[TB] FAIL credit_pulse: got %b expected 0", credit_valid); else passes++;
    endtask

    task automatic test_vc_isolation();
        logic [WIDTH-1:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            d = {$urandom, $urandom};
            do_cycle(1, 1'b0, d, 0, 1'b1);
        end
        do_cycle(1, 1'b1, 64'hA0, 0, 1'b1);
        do_cycle(1, 1'b1, 64'hA1, 0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++; if (out_data !== WIDTH'(8'hA0 + i)) $display("[TB] FAIL iso_vc1_data: got %h expected %h", out_data, 8'hA0 + i); else passes++;
            do_cycle(0, 1'b0, '0, 1, 1'b1);
            checks++; if (usedw[3:0] !== 4'd8 || credit_vc !== 1'b1) $display("[TB] FAIL iso_vc0_hold: got usedw0=%0d cvc=%b expected 8/1", usedw[3:0], credit_vc); else passes++;
        end
        rd_vc = 1'b0;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            d = mhead(1'b0);
            checks++; if (out_data !== d) $display("[TB] FAIL iso_vc0_data: got %h expected %h", out_data, d); else passes++;
            do_cycle(0, 1'b0, '0, 1, 1'b0);
        end
        checks++; if (usedw !== 8'h00) $display("[TB] FAIL iso_final: got %h expected 00", usedw); else passes++;
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] sent[$];
        logic [WIDTH-1:0] d;
        for (int i = 0; i < 3; i++) begin
            d = {$urandom, $urandom};
            sent.push_back(d);
            do_cycle(1, 1'b1, d, 0, 1'b1);
        end
        for (int k = 0; k < 20; k++) begin
            d = {$urandom, $urandom};
            sent.push_back(d);
            checks++; if (out_data !== sent[k]) $display("[TB] FAIL stream_data: got %h expected %h", out_data, sent[k]); else passes++;
            do_cycle(1, 1'b1, d, 1, 1'b1);
            checks++; if (usedw[7:4] !== 4'd3 || credit_valid !== 1'b1) $display("[TB] FAIL stream_usedw: got %0d cv=%b expected 3/1", usedw[7:4], credit_valid); else passes++;
        end
        for (int k = 20; k < 23; k++) begin
            checks++; if (out_data !== sent[k]) $display("[TB] FAIL stream_tail: got %h expected %h", out_data, sent[k]); else passes++;
            do_cycle(0, 1'b1, '0, 1, 1'b1);
        end
    endtask

    task automatic test_underflow();
        checks++; if (err_underflow !== 1'b0) $display("[TB] FAIL unf_early: got %b expected 0", err_underflow); else passes++;
        do_cycle(0, 1'b0, '0, 1, 1'b0);
        checks++; if (err_underflow !== 1'b1 || usedw[3:0] !== 4'd0 || credit_valid !== 1'b0) $display("[TB] FAIL underflow: got unf=%b usedw0=%0d cv=%b expected 1/0/0", err_underflow, usedw[3:0], credit_valid); else passes++;
        do_cycle(1, 1'b0, 64'hC0, 1, 1'b0);
        checks++; if (usedw[3:0] !== 4'd1 || credit_valid !== 1'b0 || out_data !== 64'hC0) $display("[TB] FAIL no_bypass: got usedw0=%0d cv=%b data=%h expected 1/0/c0", usedw[3:0], credit_valid, out_data); else passes++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) do_cycle(1, 1'b0, {$urandom, $urandom}, 0, 1'b0);
        do_cycle(1, 1'b0, {$urandom, $urandom}, 1, 1'b0);
        checks++; if (usedw[3:0] !== 4'd5 || credit_valid !== 1'b1) $display("[TB] FAIL pre_reset: got usedw0=%0d cv=%b expected 5/1", usedw[3:0], credit_valid); else passes++;
        produce = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++; if (empty !== 2'b11 || usedw !== 8'h00) $display("[TB] FAIL async_state: got empty=%b usedw=%h expected 11/00", empty, usedw); else passes++;
        checks++; if ({credit_valid, err_overflow, err_underflow, out_valid} !== 4'b0) $display("[TB] FAIL async_flags: got %b expected 0000", {credit_valid, err_overflow, err_underflow, out_valid}); else passes++;
        produce = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_cycle(1, 1'b0, 64'hB0, 0, 1'b0);
        do_cycle(1, 1'b0, 64'hB1, 0, 1'b0);
        checks++; if (out_data !== 64'hB0 || usedw !== 8'h02) $display("[TB] FAIL restart: got data=%h usedw=%h expected b0/02", out_data, usedw); else passes++;
    endtask

    task automatic test_random();
        bit p, c;
        logic ivc, rvc;
        for (int n = 0; n < 400; n++) begin
            p   = ($urandom_range(99) < 55);
            c   = ($urandom_range(99) < 45);
            ivc = 1'($urandom_range(1));
            rvc = 1'($urandom_range(1));
            do_cycle(p, ivc, {$urandom, $urandom}, c, rvc);
            checks++; if (usedw !== exp_usedw() || full !== exp_full() || empty !== exp_empty() || almost_full !== exp_af()) $display("[TB] FAIL rand_status: got usedw=%h f=%b e=%b af=%b expected %h/%b/%b/%b", usedw, full, empty, almost_full, exp_usedw(), exp_full(), exp_empty(), exp_af()); else passes++;
            checks++; if (out_valid !== (msize(rvc) > 0) || out_data !== mhead(rvc)) $display("[TB] FAIL rand_head: got %b/%h expected %b/%h", out_valid, out_data, (msize(rvc) > 0), mhead(rvc)); else passes++;
            checks++; if (credit_valid !== m_cv || (m_cv && credit_vc !== m_cvc)) $display("[TB] FAIL rand_credit: got %b/%b expected %b/%b", credit_valid, credit_vc, m_cv, m_cvc); else passes++;
            checks++; if (err_overflow !== m_ovf || err_underflow !== m_unf) $display("[TB] FAIL rand_err: got %b/%b expected %b/%b", err_overflow, err_underflow, m_ovf, m_unf); else passes++;
        end
    endtask

    // Scenario sequence followed by the summary.
    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_fill_overflow();
        test_drain();
        test_vc_isolation();
        test_stream();
        test_underflow();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
